// File: rtl/shift_pipe.sv
// Three-stage pipelined 32-bit barrel shifter (SRL/SLL/SRA, 0-31 bits) with
// lock-step valid/ready flow control and synchronous flush.
module shift_pipe (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic [4:0]  in_shamt,
  input  logic [1:0]  in_op,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        busy
);

  typedef enum logic [1:0] {
    OP_SRL = 2'b00,
    OP_SLL = 2'b01,
    OP_SRA = 2'b10
  } shift_op_e;

  function automatic logic [31:0] bit_rev(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  // Stage S1: captured operand
  logic        s1_valid_q, s1_valid_d;
  logic [31:0] s1_data_q,  s1_data_d;
  logic [4:0]  s1_shamt_q, s1_shamt_d;
  logic [1:0]  s1_op_q,    s1_op_d;
  logic        s1_fill_q,  s1_fill_d;

  // Stage S2: coarse (16/8) shift applied
  logic        s2_valid_q, s2_valid_d;
  logic [31:0] s2_data_q,  s2_data_d;
  logic [2:0]  s2_shamt_q, s2_shamt_d;
  logic [1:0]  s2_op_q,    s2_op_d;
  logic        s2_fill_q,  s2_fill_d;

  // Stage S3: output register
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_data_q,  out_data_d;

  logic        adv;
  logic        accept;
  logic [31:0] s2_shift;
  logic [31:0] s3_shift;

  // Stalls are all-or-nothing: bubbles stay in place rather than collapsing.
  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv && !flush;
  assign accept   = in_valid && in_ready;

  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latches).
    s1_valid_d  = s1_valid_q;
    s1_data_d   = s1_data_q;
    s1_shamt_d  = s1_shamt_q;
    s1_op_d     = s1_op_q;
    s1_fill_d   = s1_fill_q;
    s2_valid_d  = s2_valid_q;
    s2_data_d   = s2_data_q;
    s2_shamt_d  = s2_shamt_q;
    s2_op_d     = s2_op_q;
    s2_fill_d   = s2_fill_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    s2_shift = s1_data_q;
    if (s1_shamt_q[4]) s2_shift = {{16{s1_fill_q}}, s2_shift[31:16]};
    if (s1_shamt_q[3]) s2_shift = {{8{s1_fill_q}},  s2_shift[31:8]};

    s3_shift = s2_data_q;
    if (s2_shamt_q[2]) s3_shift = {{4{s2_fill_q}}, s3_shift[31:4]};
    if (s2_shamt_q[1]) s3_shift = {{2{s2_fill_q}}, s3_shift[31:2]};
    if (s2_shamt_q[0]) s3_shift = {s2_fill_q,      s3_shift[31:1]};

    if (adv) begin
      // SLL is done as a right shift on bit-reversed data, reversed back in S3.
      s1_valid_d  = accept;
      s1_data_d   = (in_op == OP_SLL) ? bit_rev(in_data) : in_data;
      s1_shamt_d  = in_shamt;
      s1_op_d     = in_op;
      s1_fill_d   = (in_op == OP_SRA) ? in_data[31] : 1'b0;

      s2_valid_d  = s1_valid_q;
      s2_data_d   = s2_shift;
      s2_shamt_d  = s1_shamt_q[2:0];
      s2_op_d     = s1_op_q;
      s2_fill_d   = s1_fill_q;

      out_valid_d = s2_valid_q;
      out_data_d  = (s2_op_q == OP_SLL) ? bit_rev(s3_shift) : s3_shift;
    end

    if (flush) begin
      s1_valid_d  = 1'b0;
      s2_valid_d  = 1'b0;
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: data registers are reset too, since out_data must read zero in reset.
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_shamt_q  <= '0;
      s1_op_q     <= '0;
      s1_fill_q   <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_data_q   <= '0;
      s2_shamt_q  <= '0;
      s2_op_q     <= '0;
      s2_fill_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      // NOTE: non-blocking so every stage samples the previous stage's old value.
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s1_shamt_q  <= s1_shamt_d;
      s1_op_q     <= s1_op_d;
      s1_fill_q   <= s1_fill_d;
      s2_valid_q  <= s2_valid_d;
      s2_data_q   <= s2_data_d;
      s2_shamt_q  <= s2_shamt_d;
      s2_op_q     <= s2_op_d;
      s2_fill_q   <= s2_fill_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = s1_valid_q || s2_valid_q || out_valid_q;

endmodule

// File: tb/tb_shift_pipe.sv
// Directed self-checking bench for shift_pipe: single ops with latency check,
// back-to-back with backpressure, flush and mid-stream asynchronous reset.
module tb_shift_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_shamt;
  logic [1:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  shift_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [1:0] op, input logic [31:0] data, input logic [4:0] sh);
    in_valid = 1'b1;
    in_op    = op;
    in_data  = data;
    in_shamt = sh;
  endtask

  // Accept at the first edge, result must be visible right after the third edge.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] data,
                        input logic [4:0] sh, input logic [31:0] exp);
    present(op, data, sh);
    step();
    in_valid = 1'b0;
    step();
    check({tag, "_early"}, {31'b0, out_valid}, 32'd0);
    step();
    check({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
    check({tag, "_data"}, out_data, exp);
  endtask

  logic [1:0]  b_op   [4] = '{2'b00, 2'b01, 2'b10, 2'b00};
  logic [31:0] b_data [4] = '{32'hF0F0_0000, 32'h0000_00FF, 32'h8000_0000, 32'h1234_5678};
  logic [4:0]  b_sh   [4] = '{5'd4, 5'd8, 5'd16, 5'd12};
  logic [31:0] b_exp  [4] = '{32'h0F0F_0000, 32'h0000_FF00, 32'hFFFF_8000, 32'h0001_2345};

  initial begin
    int  idx;
    int  got;
    int  stall;
    bit  stalled_once;
    bit  acc;
    bit  fire;

    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_shamt  = '0;
    in_op     = '0;
    out_ready = 1'b1;

    #12;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    step();
    rst_n = 1'b1;

    run_op("srl8",      2'b00, 32'h8000_00F0, 5'd8,  32'h0080_0000);
    run_op("sra31",     2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF);
    run_op("sra4_pos",  2'b10, 32'h7FFF_FFFF, 5'd4,  32'h07FF_FFFF);
    run_op("op11",      2'b11, 32'hF000_0000, 5'd4,  32'h0F00_0000);
    run_op("sll31",     2'b01, 32'h0000_0001, 5'd31, 32'h8000_0000);
    run_op("sll4",      2'b01, 32'h1234_5678, 5'd4,  32'h2345_6780);
    run_op("srl0",      2'b00, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF);
    run_op("sll0",      2'b01, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF);
    run_op("sra0",      2'b10, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF);
    run_op("sra27",     2'b10, 32'hF000_0000, 5'd27, 32'hFFFF_FFFE);

    // Back-to-back with a two-cycle consumer stall after the first result.
    repeat (3) step();
    idx = 0; got = 0; stall = 0; stalled_once = 0;
    present(b_op[0], b_data[0], b_sh[0]);
    for (int c = 0; c < 20 && got < 4; c++) begin
      @(negedge clk);
      acc  = in_valid && in_ready;
      fire = out_valid && out_ready;
      if (stall > 0) begin
        check("stall_in_ready", {31'b0, in_ready}, 32'd0);
        check("stall_hold", out_data, b_exp[0]);
      end
      if (fire) begin
        check($sformatf("b2b_%0d", got), out_data, b_exp[got]);
        got++;
      end
      step();
      if (acc) idx++;
      if (idx < 4) present(b_op[idx], b_data[idx], b_sh[idx]);
      else in_valid = 1'b0;
      if (stall > 0) stall--;
      if (out_valid && !stalled_once) begin
        stalled_once = 1;
        stall = 2;
      end
      out_ready = (stall == 0);
    end
    check("b2b_count", got, 32'd4);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();

    // Flush with two operations in flight and a third presented.
    present(2'b00, 32'hAAAA_0000, 5'd0);
    step();
    present(2'b01, 32'h0000_5555, 5'd1);
    step();
    present(2'b10, 32'h8000_0001, 5'd2);
    flush = 1'b1;
    #1;
    check("flush_in_ready", {31'b0, in_ready}, 32'd0);
    check("flush_busy_before", {31'b0, busy}, 32'd1);
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_out_valid", {31'b0, out_valid}, 32'd0);
    check("flush_busy", {31'b0, busy}, 32'd0);
    for (int c = 0; c < 4; c++) begin
      step();
      check("flush_no_leak", {31'b0, out_valid}, 32'd0);
    end

    // Asynchronous reset with all three stages occupied.
    present(2'b00, 32'h1111_1111, 5'd1);
    step();
    present(2'b00, 32'h2222_2222, 5'd2);
    step();
    present(2'b00, 32'h3333_3333, 5'd3);
    step();
    in_valid = 1'b0;
    check("pre_rst_busy", {31'b0, busy}, 32'd1);
    check("pre_rst_out_valid", {31'b0, out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("mid_rst_out_data", out_data, 32'h0);
    check("mid_rst_busy", {31'b0, busy}, 32'd0);
    step();
    rst_n = 1'b1;
    run_op("post_rst_srl1", 2'b00, 32'hFFFF_FFFF, 5'd1, 32'h7FFF_FFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shift_pipe.md
# shift_pipe

Three-stage pipelined 32-bit shift unit for the execute stage of the pipelined datapath. It performs logical-right, logical-left and arithmetic-right shifts by 0–31 bits using a 16/8 and 4/2/1 decomposition. Registers separate the stages, with valid/ready flow control and a synchronous flush. It sits between the ID/EX operand latch and the EX/MEM result mux, and is the sequential wrapper around the per-amount shift stages.

## Interface
- No parameters; data width fixed at 32, shift amount at 5 bits.
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous reset, active low
- flush  input  1  synchronous kill of all in-flight operations
- in_valid  input  1  operand presented
- in_ready  output  1  unit accepts operand this cycle
- in_data  input  32  operand
- in_shamt  input  5  shift amount 0–31
- in_op  input  2  00 SRL, 01 SLL, 10 SRA, 11 treated as SRL
- out_valid  output  1  result valid
- out_ready  input  1  consumer takes result this cycle
- out_data  output  32  shifted result
- busy  output  1  any stage holds a valid operation

## Operation
- Stage S1 (capture register): stores data, shamt, op, fill bit and valid.
  - SLL: data is stored bit-reversed.
  - fill = in_data[31] for SRA, else 0.
- Stage S2: applies right shift by 16 if shamt[4], then by 8 if shamt[3]. Vacated bits take the fill bit. Registers the result with shamt[2:0], op and valid.
- Stage S3 (output register): applies right shift by 4/2/1 per shamt[2:0] with fill. Bit-reverses again for SLL. Registers into out_data and out_valid.
- Shift semantics:
  - shamt 0 passes data unchanged for every op.
  - SRA by 31 yields all copies of bit 31.
  - No shift amount of 32 or more exists.
- Global advance: adv = !out_valid | out_ready. All three stages load together when adv=1 and hold when adv=0. Bubbles are not collapsed.
- in_ready = adv & !flush. An operand is accepted when in_valid & in_ready.
- Flush: clears S1, S2 and S3 valid bits at the next edge regardless of out_ready. Nothing is accepted that cycle. Data registers are don't-care after flush.
- busy = S1.valid | S2.valid | out_valid.
- Reset (asynchronous, any time, including mid-operation):
  - all valid bits 0
  - out_data = 0x0000_0000
  - out_valid = 0
  - busy = 0
  - in_ready = 1 once rst_n is high; it depends only on out_valid, out_ready and flush, so it is combinational.

## Timing
- Acceptance in cycle n (sampled at the end of n) gives S1 valid in n+1, S2 in n+2, and out_valid with the result in n+3. Latency is 3 cycles.
- Throughput is one operation per cycle while out_ready=1.
- When out_valid=1 and out_ready=0:
  - out_data, out_valid and all stage contents hold;
  - in_ready=0.
- Results leave in acceptance order. None are dropped or duplicated.
- out_valid & out_ready in the same cycle as a new acceptance: pipeline advances, old result retires, new operand enters S1.
- flush and out_ready=1 in the same cycle: the current result counts as consumed, then all valid bits clear.
- No combinational path from in_* to out_*. in_ready is combinational from out_valid, out_ready and flush only.

## Test plan
- SRL 0x8000_00F0, shamt 8, out_ready=1 → out_data 0x0080_0000, out_valid high exactly 3 cycles after acceptance.
- SRA 0x8000_0000 shamt 31 → 0xFFFF_FFFF. SRA 0x7FFF_FFFF shamt 4 → 0x07FF_FFFF. op 11 on 0xF000_0000 shamt 4 → 0x0F00_0000.
- SLL 0x0000_0001 shamt 31 → 0x8000_0000. SLL 0x1234_5678 shamt 4 → 0x2345_6780. All three ops with shamt 0 on 0xDEAD_BEEF → 0xDEAD_BEEF.
- Four back-to-back operations, with out_ready held low for 2 cycles once the first result appears → in_ready low for those 2 cycles, out_data stable, all four results emerge in order with no loss.
- Two operations in flight, flush pulsed for 1 cycle with in_valid high → next cycle out_valid=0, busy=0; the flushed and presented operands never appear at the output.
- rst_n driven low mid-stream with 3 valid stages → immediately out_valid=0, out_data=0, busy=0. After release, a new SRL 0xFFFF_FFFF shamt 1 → 0x7FFF_FFFF after 3 cycles.
